cosine_cordic_core: RTL and testbench

COSINE_CORDIC_CORE -- requirements
Module: cosine_cordic_core

---
 rtl/cosine_cordic_core.sv | 149 ++++++++++++++
 tb/tb_cosine_cordic_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cosine_cordic_core.sv
// Iterative rotation-mode CORDIC that computes cos(angle) for Q1.20 angles in 0..1.0 rad.
// Each computation takes 20 RUN iterations and one DONE cycle; clk_en freezes everything.
module cosine_cordic_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [20:0] angle,
    output logic        busy,
    output logic        done,
    output logic [20:0] result
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // CORDIC gain compensation K = 0.607252935 in Q1.20
    localparam logic signed [22:0] KInit   = 23'sd636751;
    localparam logic signed [22:0] OneQ120 = 23'sd1048576;
    localparam logic [4:0]         LastIt  = 5'd19;

    state_e             state_q, state_d;
    logic signed [22:0] x_q, x_d;
    logic signed [22:0] y_q, y_d;
    logic signed [22:0] z_q, z_d;
    logic [4:0]         i_q, i_d;
    logic               done_q, done_d;
    logic [20:0]        result_q, result_d;

    logic signed [22:0] x_sh, y_sh, atan_i;
    logic [20:0]        x_clamped;

    // round(atan(2^-i) * 2^20)
    function automatic logic signed [22:0] atan_lut(input logic [4:0] idx);
        logic signed [22:0] val;
        case (idx)
            5'd0:    val = 23'sd823550;
            5'd1:    val = 23'sd486170;
            5'd2:    val = 23'sd256879;
            5'd3:    val = 23'sd130396;
            5'd4:    val = 23'sd65451;
            5'd5:    val = 23'sd32757;
            5'd6:    val = 23'sd16383;
            5'd7:    val = 23'sd8192;
            5'd8:    val = 23'sd4096;
            5'd9:    val = 23'sd2048;
            5'd10:   val = 23'sd1024;
            5'd11:   val = 23'sd512;
            5'd12:   val = 23'sd256;
            5'd13:   val = 23'sd128;
            5'd14:   val = 23'sd64;
            5'd15:   val = 23'sd32;
            5'd16:   val = 23'sd16;
            5'd17:   val = 23'sd8;
            5'd18:   val = 23'sd4;
            5'd19:   val = 23'sd2;
            default: val = 23'sd0;
        endcase
        return val;
    endfunction

    // Per-iteration shifted operands and clamped output candidate
    always_comb begin
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_i = atan_lut(i_q);
        if (x_q[22]) begin
            x_clamped = 21'd0;
        end else if (x_q > OneQ120) begin
            x_clamped = 21'd1048576;
        end else begin
            x_clamped = x_q[20:0];
        end
    end

    // Next-state logic: FSM sequencing plus one CORDIC micro-rotation per RUN cycle
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        i_d      = i_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = KInit;
                    y_d     = 23'sd0;
                    z_d     = {2'b00, angle};
                    i_d     = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // z >= 0 rotates positively (d = +1)
                if (!z_q[22]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                i_d = i_q + 5'd1;
                if (i_q == LastIt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d   = 1'b1;
                result_d = x_clamped;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register: reset wins over clk_en; clk_en low freezes everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            x_q      <= 23'sd0;
            y_q      <= 23'sd0;
            z_q      <= 23'sd0;
            i_q      <= 5'd0;
            done_q   <= 1'b0;
            result_q <= 21'd0;
        end else if (clk_en) begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            i_q      <= i_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Outputs
    always_comb begin
        busy   = (state_q != StIdle);
        done   = done_q;
        result = result_q;
    end

endmodule

// File: tb/tb_cosine_cordic_core.sv
// Self-checking bench for cosine_cordic_core: directed scenarios plus random angles
// compared against a floating-point cosine reference.
module tb_cosine_cordic_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [20:0] angle = 21'd0;
    logic        busy;
    logic        done;
    logic [20:0] result;

    int checks = 0;
    int errors = 0;

    cosine_cordic_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .angle   (angle),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Ideal cos(a) in Q1.20, rounded
    function automatic int ref_cos(input int ang);
        real r;
        r = $cos(real'(ang) / 1048576.0) * 1048576.0;
        return $rtoi(r + 0.5);
    endfunction

    // Pulse start for one edge; lat = edges after the accepting edge until done seen (-1 = timeout)
    task automatic run_one(input int ang, output int res, output int lat);
        angle = 21'(ang);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        res = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done) begin
                lat = k;
                res = int'(result);
                break;
            end
        end
    endtask

    initial begin
        int res, lat, r0, prev, ndone, first_ang, a, exp_c;

        // Reset state
        reset_n = 1'b0;
        step();
        step();
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_result", int'(result), 0);
        reset_n = 1'b1;
        step();

        // angle = 0.5
        run_one(524288, res, lat);
        check_eq("lat_0p5", lat, 21);
        check_rng("cos_0p5", res, 920211 - 8, 920211 + 8);
        check_eq("busy_at_done", int'(busy), 0);
        step();
        check_eq("done_single_cycle", int'(done), 0);
        check_eq("result_hold_idle", int'(result), res);

        // angle = 0 and angle = 1.0
        run_one(0, res, lat);
        check_eq("lat_zero", lat, 21);
        check_rng("cos_zero", res, 1048576 - 8, 1048576);
        run_one(1048576, res, lat);
        check_eq("lat_one", lat, 21);
        check_rng("cos_one", res, 566548 - 8, 566548 + 8);

        // result must not change while a new computation runs
        prev = res;
        angle = 21'd100000;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check_eq("busy_in_run", int'(busy), 1);
        check_eq("result_hold_run", int'(result), prev);
        for (int k = 0; k < 40 && busy; k++) step();
        step();

        // Random in-range angles; CORDIC truncation error allowance slightly wider here
        for (int n = 0; n < 8; n++) begin
            a = int'($urandom_range(0, 1048576));
            exp_c = ref_cos(a);
            run_one(a, res, lat);
            check_eq("lat_rand", lat, 21);
            check_rng("cos_rand", res, exp_c - 12, exp_c + 12);
        end

        // Out-of-range angles: must complete and stay within the clamp range
        for (int n = 0; n < 3; n++) begin
            a = int'($urandom_range(1048577, 2097151));
            run_one(a, res, lat);
            check_eq("lat_oor", lat, 21);
            check_rng("clamp_oor", res, 0, 1048576);
        end

        // start held high for 30 cycles with changing angle: exactly one done in the window
        ndone = 0;
        first_ang = 0;
        res = -1;
        step();
        for (int c = 0; c < 30; c++) begin
            angle = 21'($urandom_range(0, 1048576));
            if (c == 0) first_ang = int'(angle);
            start = 1'b1;
            step();
            if (done) begin
                ndone++;
                res = int'(result);
            end
        end
        start = 1'b0;
        check_eq("hammer_done_count", ndone, 1);
        exp_c = ref_cos(first_ang);
        check_rng("hammer_first_angle", res, exp_c - 12, exp_c + 12);
        for (int k = 0; k < 60 && busy; k++) step();
        step();

        // Stall: 5 cycles of clk_en low mid-RUN delays done by exactly 5
        run_one(700000, r0, lat);
        check_eq("lat_unstalled", lat, 21);
        step();
        angle = 21'd700000;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        repeat (8) begin
            step();
            lat++;
        end
        clk_en = 1'b0;
        repeat (5) begin
            step();
            lat++;
            check_eq("stall_no_done", int'(done), 0);
        end
        check_eq("stall_busy", int'(busy), 1);
        clk_en = 1'b1;
        res = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            lat++;
            if (done) begin
                res = int'(result);
                break;
            end
        end
        check_eq("lat_stalled", lat, 26);
        check_eq("stall_result", res, r0);

        // clk_en low while done is high keeps done asserted
        clk_en = 1'b0;
        repeat (3) begin
            step();
            check_eq("done_held_stall", int'(done), 1);
        end
        clk_en = 1'b1;
        step();
        check_eq("done_clears", int'(done), 0);

        // Reset pulse at RUN iteration 10 aborts the computation
        angle = 21'd300000;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_result", int'(result), 0);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);
        run_one(1048576, res, lat);
        check_eq("lat_after_abort", lat, 21);
        check_rng("cos_after_abort", res, 566548 - 8, 566548 + 8);
        step();

        // Back-to-back: second start in the IDLE cycle where the first done is high
        run_one(524288, res, lat);
        check_eq("b2b_lat1", lat, 21);
        check_rng("b2b_cos1", res, 920211 - 8, 920211 + 8);
        run_one(1048576, res, lat);
        check_eq("b2b_lat2", lat, 21);
        check_rng("b2b_cos2", res, 566548 - 8, 566548 + 8);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
